// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM read-port arbiter.
//   arb_state_e  - arbiter sequencing state (idle / run / drain)
//   trk_entry_t  - one in-flight read slot {valid, id, err}
//   DEPTH_DEFAULT, ID_W - default SRAM depth and requester-index width
//   addr_in_range() - true when a read address falls inside the SRAM
package sram_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 1024;
  localparam int unsigned ID_W          = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } trk_entry_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NUM_REQ request lines.
//   req_i   - request vector
//   ptr_i   - index of the previous winner; search starts at ptr_i+1
//   gnt_o   - one-hot winner (all zero when no request)
//   idx_o   - binary index of the winner
//   valid_o - high when any request is set
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;
  int              ptr_int;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest
  // requester at or below it.
  always_comb begin
    ptr_int  = int'(ptr_i);
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_i[i] && (i > ptr_int) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (req_i[i] && (i <= ptr_int) && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
    end
    valid_o = hi_found | lo_found;
    idx_o   = hi_found ? hi_idx : lo_idx;
    gnt_o   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      gnt_o[i] = valid_o && (ID_W'(i) == idx_o);
    end
  end

endmodule

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter: round-robin arbiter and read sequencer for the single read
// port of the input-buffer SRAM. One grant per cycle; returned data is tagged
// with the requester index RD_LAT cycles after the grant.
//
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   enable           - gates new grants; in-flight reads still complete
//   req, req_addr    - per-requester level request and address
//                      (requester i at req_addr[i*ADDR_W +: ADDR_W])
//   gnt              - registered one-hot grant pulse
//   sram_addr        - registered SRAM read address
//   sram_data        - SRAM read data
//   rd_valid, rd_data, rd_id, rd_err - returned word, its requester and
//                      out-of-range flag, strobed by rd_valid
//   idle             - no read in flight and no grant this cycle
//
// Build option: define SRAM_RD_ARB_RANGE_CHK_EN to flag granted addresses at or
// beyond DEPTH (address not driven, word returned as 0 with rd_err). Without
// it the address wraps modulo DEPTH and rd_err stays 0.
module sram_rd_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         sram_addr,
  input  logic [DATA_W-1:0]         sram_data,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ID_W-1:0]           rd_id,
  output logic                      rd_err,
  output logic                      idle
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;
  logic               rd_err_q, rd_err_d;
  logic               idle_q, idle_d;
  arb_state_e         state_q, state_d;

  trk_entry_t trk_q [RD_LAT];
  trk_entry_t trk_d [RD_LAT];
  trk_entry_t trk_out;
  logic       inflight_d;

  // Arbitration
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic               grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign grant = enable & pick_valid;

  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_oh[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Address path
  logic addr_err;

`ifdef SRAM_RD_ARB_RANGE_CHK_EN
  assign addr_err = !addr_in_range(32'(sel_addr), DEPTH);

  // An out-of-range grant leaves the SRAM re-reading its previous address.
  always_comb begin
    sram_addr_d = sram_addr_q;
    if (grant && !addr_err) begin
      sram_addr_d = sel_addr;
    end
  end
`else
  assign addr_err = 1'b0;

  always_comb begin
    sram_addr_d = sram_addr_q;
    if (grant) begin
      sram_addr_d = ADDR_W'(32'(sel_addr) % DEPTH);
    end
  end
`endif

  assign ptr_d = grant ? pick_idx : ptr_q;
  assign gnt_d = grant ? pick_oh : '0;

  // In-flight tracker: slot 0 takes this edge's grant, the last slot is the
  // read whose data is on sram_data now.
  always_comb begin
    trk_d[0] = '{valid: grant, id: pick_idx, err: grant & addr_err};
    for (int i = 1; i < int'(RD_LAT); i++) begin
      trk_d[i] = trk_q[i-1];
    end
    trk_out    = trk_q[RD_LAT-1];
    inflight_d = 1'b0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight_d = inflight_d | trk_d[i].valid;
    end
  end

  // Return path
  always_comb begin
    rd_valid_d = trk_out.valid;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_err_d   = rd_err_q;
    if (trk_out.valid) begin
      rd_data_d = trk_out.err ? '0 : sram_data;
      rd_id_d   = trk_out.id;
      rd_err_d  = trk_out.err;
    end
  end

  // A word being returned still counts as busy, so idle rises one cycle
  // after the last rd_valid.
  assign idle_d = !grant && !inflight_d && !rd_valid_d;

  // Sequencing state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = (inflight_d || rd_valid_d) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (!inflight_d && !rd_valid_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      sram_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_id_q     <= '0;
      rd_err_q    <= 1'b0;
      idle_q      <= 1'b1;
      state_q     <= StIdle;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      sram_addr_q <= sram_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_id_q     <= rd_id_d;
      rd_err_q    <= rd_err_d;
      idle_q      <= idle_d;
      state_q     <= state_d;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  assign gnt       = gnt_q;
  assign sram_addr = sram_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_id     = rd_id_q;
  assign rd_err    = rd_err_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// tb_sram_rd_arbiter: two arbiters (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream. A round-robin model predicts each grant; the expected returned word
// is queued per instance at grant time and popped when its due cycle arrives.
module tb_sram_rd_arbiter;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  req;
  logic [51:0] req_addr;

  logic [3:0]  gnt1, gnt3;
  logic [12:0] sram_addr1, sram_addr3;
  logic [7:0]  sram_data1, sram_data3;
  logic        rd_valid1, rd_valid3;
  logic [7:0]  rd_data1, rd_data3;
  logic [2:0]  rd_id1, rd_id3;
  logic        rd_err1, rd_err3;
  logic        idle1, idle3;

  always #5 clock = ~clock;

  sram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(8), .DEPTH(1024), .RD_LAT(1)) u_dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt1),
    .sram_addr (sram_addr1),
    .sram_data (sram_data1),
    .rd_valid  (rd_valid1),
    .rd_data   (rd_data1),
    .rd_id     (rd_id1),
    .rd_err    (rd_err1),
    .idle      (idle1)
  );

  sram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(13), .DATA_W(8), .DEPTH(1024), .RD_LAT(3)) u_dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt3),
    .sram_addr (sram_addr3),
    .sram_data (sram_data3),
    .rd_valid  (rd_valid3),
    .rd_data   (rd_data3),
    .rd_id     (rd_id3),
    .rd_err    (rd_err3),
    .idle      (idle3)
  );

  // SRAM models: asynchronous for latency 1, two internal stages for latency 3.
  logic [7:0]  mem [1024];
  logic [12:0] a3_p1, a3_p2;

  assign sram_data1 = mem[sram_addr1[9:0]];
  always @(posedge clock) begin
    a3_p1 <= sram_addr3;
    a3_p2 <= a3_p1;
  end
  assign sram_data3 = mem[a3_p2[9:0]];

  // Model and bookkeeping
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          ptr_m;
  logic [12:0] exp_saddr;
  exp_t        q1[$];
  exp_t        q3[$];
  int          gseq[$];
  int          rlist [4][16];
  int          rhead [4];
  int          rcnt  [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] r);
    logic [1:0] ix;
    for (int off = 1; off <= 4; off++) begin
      ix = 2'(ptr + off);
      if (r[ix]) return int'(ix);
    end
    return -1;
  endfunction

  function automatic exp_t mk_exp(input int id, input int addr, input int due);
    exp_t       e;
    logic [9:0] ma;
    ma    = 10'(addr);
    e.id  = 3'(id);
    e.due = due;
`ifdef SRAM_RD_ARB_RANGE_CHK_EN
    if (addr >= 1024) begin
      e.err  = 1'b1;
      e.data = 8'h00;
    end else begin
      e.err  = 1'b0;
      e.data = mem[ma];
    end
`else
    e.err  = 1'b0;
    e.data = mem[ma];
`endif
    return e;
  endfunction

  function automatic logic [12:0] next_saddr(input int addr, input logic [12:0] prev);
`ifdef SRAM_RD_ARB_RANGE_CHK_EN
    return (addr >= 1024) ? prev : 13'(addr);
`else
    return 13'(addr % 1024);
`endif
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (rhead[i] < rcnt[i]) begin
        req[i] = 1'b1;
        req_addr[i*13 +: 13] = 13'(rlist[i][rhead[i]]);
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic check_ret(input string tag, input logic [2:0] id, input logic [7:0] d,
                           input logic er, input exp_t e);
    check_eq({"rd_id", tag}, 32'(id), 32'(e.id));
    check_eq({"rd_data", tag}, 32'(d), 32'(e.data));
    check_eq({"rd_err", tag}, 32'(er), 32'(e.err));
  endtask

  // One clock: predict this edge's grant, then check both instances.
  task automatic step();
    int         w;
    int         a;
    logic [3:0] eg;
    logic       ev;
    logic       ei;
    exp_t       e;
    @(posedge clock);
    cyc++;
    eg = 4'b0;
    if (enable && (req != 4'b0)) begin
      w      = rr_pick(ptr_m, req);
      ptr_m  = w;
      eg     = 4'(1 << w);
      a      = rlist[w][rhead[w]];
      rhead[w]++;
      q1.push_back(mk_exp(w, a, cyc + 1));
      q3.push_back(mk_exp(w, a, cyc + 3));
      exp_saddr = next_saddr(a, exp_saddr);
    end
    #1;
    check_eq("gnt1", 32'(gnt1), 32'(eg));
    check_eq("gnt3", 32'(gnt3), 32'(eg));
    check_eq("sram_addr1", 32'(sram_addr1), 32'(exp_saddr));
    check_eq("sram_addr3", 32'(sram_addr3), 32'(exp_saddr));
    for (int i = 0; i < 4; i++) begin
      if (gnt1[i]) gseq.push_back(i);
    end

    ei = (eg == 4'b0) && (q1.size() == 0);
    check_eq("idle1", 32'(idle1), 32'(ei));
    ev = (q1.size() > 0) && (q1[0].due == cyc);
    check_eq("rd_valid1", 32'(rd_valid1), 32'(ev));
    if (ev) begin
      e = q1.pop_front();
      if (rd_valid1) check_ret("1", rd_id1, rd_data1, rd_err1, e);
    end

    ei = (eg == 4'b0) && (q3.size() == 0);
    check_eq("idle3", 32'(idle3), 32'(ei));
    ev = (q3.size() > 0) && (q3[0].due == cyc);
    check_eq("rd_valid3", 32'(rd_valid3), 32'(ev));
    if (ev) begin
      e = q3.pop_front();
      if (rd_valid3) check_ret("3", rd_id3, rd_data3, rd_err3, e);
    end

    drive_reqs();
  endtask

  function automatic logic pending();
    for (int i = 0; i < 4; i++) begin
      if (rhead[i] < rcnt[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_until_done(input int maxc);
    int n;
    n = 0;
    while ((pending() || (q1.size() > 0) || (q3.size() > 0)) && (n < maxc)) begin
      step();
      n++;
    end
    check_eq("drain_timeout", 32'(n >= maxc), 32'(0));
    step();
  endtask

  // Reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0;
      rcnt[i]  = 0;
    end
    req       = 4'b0;
    enable    = 1'b1;
    ptr_m     = 3;
    exp_saddr = 13'd0;
    q1.delete();
    q3.delete();
    gseq.delete();
    #1;
    check_eq("rst_gnt1", 32'(gnt1), 32'(0));
    check_eq("rst_gnt3", 32'(gnt3), 32'(0));
    check_eq("rst_saddr1", 32'(sram_addr1), 32'(0));
    check_eq("rst_saddr3", 32'(sram_addr3), 32'(0));
    check_eq("rst_valid1", 32'(rd_valid1), 32'(0));
    check_eq("rst_valid3", 32'(rd_valid3), 32'(0));
    check_eq("rst_data1", 32'(rd_data1), 32'(0));
    check_eq("rst_data3", 32'(rd_data3), 32'(0));
    check_eq("rst_id1", 32'(rd_id1), 32'(0));
    check_eq("rst_id3", 32'(rd_id3), 32'(0));
    check_eq("rst_err1", 32'(rd_err1), 32'(0));
    check_eq("rst_err3", 32'(rd_err3), 32'(0));
    check_eq("rst_idle1", 32'(idle1), 32'(1));
    check_eq("rst_idle3", 32'(idle3), 32'(1));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic load_stream(input int id, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      rlist[id][k] = base + k;
    end
    rhead[id] = 0;
    rcnt[id]  = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 8'(a * 37 + 11);
    end
    mem[5]   = 8'hA5;
    reset_n  = 1'b1;
    enable   = 1'b1;
    req      = 4'b0;
    req_addr = '0;

    // Single request from requester 2.
    do_reset();
    load_stream(2, 5, 1);
    drive_reqs();
    run_until_done(20);
    check_eq("single_count", 32'(gseq.size()), 32'(1));
    if (gseq.size() > 0) check_eq("single_winner", 32'(gseq[0]), 32'(2));

    // Fairness: all four requesters hold two addresses each.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rlist[i][0] = 10 + i;
      rlist[i][1] = 20 + i;
      rcnt[i]     = 2;
    end
    drive_reqs();
    run_until_done(40);
    check_eq("fair_count", 32'(gseq.size()), 32'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < gseq.size()) check_eq("fair_order", 32'(gseq[k]), 32'(k % 4));
    end

    // Back-to-back stream from one requester.
    do_reset();
    load_stream(1, 0, 10);
    drive_reqs();
    run_until_done(40);
    check_eq("stream_count", 32'(gseq.size()), 32'(10));

    // Enable dropped mid-stream: only in-flight reads return.
    do_reset();
    load_stream(0, 100, 12);
    drive_reqs();
    repeat (4) step();
    enable = 1'b0;
    repeat (8) step();
    check_eq("drop_grants", 32'(gseq.size()), 32'(4));
    rcnt[0] = rhead[0];
    drive_reqs();
    enable = 1'b1;
    repeat (2) step();

    // Address beyond the SRAM, then an in-range one.
    do_reset();
    rlist[3][0] = 1030;
    rlist[3][1] = 7;
    rcnt[3]     = 2;
    drive_reqs();
    run_until_done(20);

    // Reset in the middle of a stream; nothing stale afterwards.
    do_reset();
    load_stream(0, 200, 8);
    drive_reqs();
    repeat (3) step();
    do_reset();
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
